// File: rtl/alu_muldiv_seq.sv
// Multi-cycle unsigned MULTU/DIVU sequencer that borrows the EX-stage ALU for one
// add or subtract per clock and accumulates the result in HI/LO.
module alu_muldiv_seq (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [2:0]  alu_ctrl,
  input  logic [31:0] alu_out
);

  localparam int         ITER     = 32;
  localparam logic [2:0] CTRL_ADD = 3'b010;
  localparam logic [2:0] CTRL_SUB = 3'b110;
  localparam logic [5:0] LAST_CNT = 6'(ITER - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]  state;
  logic [5:0]  cnt;
  logic [31:0] opr;
  logic        op_r;

  logic [31:0] s;
  logic        t;
  logic        c;
  logic        geu;
  logic        ge;

  assign busy = (state != S_IDLE);
  assign done = (state == S_DONE);

  // Divide step: shift the 64-bit {hi,lo} left by one; t is the bit pushed out of hi.
  assign s = {hi[30:0], lo[31]};
  assign t = hi[31];

  // The ALU has no carry/borrow output, so rebuild them from the operand and result MSBs.
  assign c   = (alu_a[31] & alu_b[31]) | ((alu_a[31] | alu_b[31]) & ~alu_out[31]);
  assign geu = (s[31] & ~opr[31]) | (~(s[31] ^ opr[31]) & ~alu_out[31]);
  assign ge  = t | geu;

  always_comb begin
    // NOTE: every output gets a default before the branches so no latch is inferred.
    alu_a    = '0;
    alu_b    = '0;
    alu_ctrl = 3'b000;
    if (state == S_RUN) begin
      if (op_r) begin
        alu_a    = s;
        alu_b    = opr;
        alu_ctrl = CTRL_SUB;
      end else begin
        alu_a    = hi;
        alu_b    = lo[0] ? opr : '0;
        alu_ctrl = CTRL_ADD;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every update sees pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      cnt   <= '0;
      opr   <= '0;
      op_r  <= 1'b0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            opr   <= op ? b : a;
            op_r  <= op;
            cnt   <= '0;
            hi    <= '0;
            lo    <= op ? a : b;
            state <= S_RUN;
            // Divide by zero skips the iterations entirely.
            if (op && (b == 32'd0)) begin
              hi    <= a;
              lo    <= '1;
              state <= S_DONE;
            end
          end
        end
        S_RUN: begin
          cnt <= cnt + 6'd1;
          if (op_r) begin
            hi <= ge ? alu_out : s;
            lo <= {lo[30:0], ge};
          end else begin
            {hi, lo} <= {c, alu_out, lo[31:1]};
          end
          if (cnt == LAST_CNT) state <= S_DONE;
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Self-checking bench for alu_muldiv_seq: bench-side ALU, a latency/result model built
// from plain 64-bit arithmetic, a per-cycle compare process and directed vectors.
module tb_alu_muldiv_seq;

  logic        clk;
  logic        reset;
  logic        start;
  logic        op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [2:0]  alu_ctrl;
  logic [31:0] alu_out;

  int total = 0;
  int bad   = 0;
  bit chk_en = 0;

  alu_muldiv_seq dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .op       (op),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .hi       (hi),
    .lo       (lo),
    .alu_a    (alu_a),
    .alu_b    (alu_b),
    .alu_ctrl (alu_ctrl),
    .alu_out  (alu_out)
  );

  // Stand-in for the pipeline's 32-bit ALU.
  assign alu_out = (alu_ctrl == 3'b010) ? alu_a + alu_b :
                   (alu_ctrl == 3'b110) ? alu_a - alu_b : 32'h0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: m_cyc counts cycles since the accepting edge (0 = idle); m_last is the done cycle.
  int          m_cyc  = 0;
  int          m_last = 0;
  logic        m_op   = 1'b0;
  logic [31:0] m_hi   = '0;
  logic [31:0] m_lo   = '0;

  always @(posedge clk) begin
    if (reset) begin
      m_cyc  <= 0;
      m_last <= 0;
      m_op   <= 1'b0;
      m_hi   <= '0;
      m_lo   <= '0;
    end else if (m_cyc == 0) begin
      if (start) begin
        m_cyc  <= 1;
        m_op   <= op;
        m_last <= (op && b == 32'd0) ? 1 : 33;
        if (!op)               {m_hi, m_lo} <= 64'(a) * 64'(b);
        else if (b == 32'd0)   begin m_hi <= a;     m_lo <= '1;    end
        else                   begin m_hi <= a % b; m_lo <= a / b; end
      end
    end else if (m_cyc == m_last) begin
      m_cyc <= 0;
    end else begin
      m_cyc <= m_cyc + 1;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("busy", 64'(busy), 64'(m_cyc != 0));
      check("done", 64'(done), 64'(m_cyc != 0 && m_cyc == m_last));
      if (m_cyc == 0 || m_cyc == m_last) begin
        check("hi", 64'(hi), 64'(m_hi));
        check("lo", 64'(lo), 64'(m_lo));
        check("alu_ctrl idle", 64'(alu_ctrl), 64'(3'b000));
        check("alu_a idle", 64'(alu_a), 64'h0);
        check("alu_b idle", 64'(alu_b), 64'h0);
      end else begin
        check("alu_ctrl run", 64'(alu_ctrl), m_op ? 64'h6 : 64'h2);
      end
    end
  end

  // Issue one operation, scramble the operands afterwards, and pin latency and results.
  task automatic do_op(input string nm, input logic o, input logic [31:0] x, input logic [31:0] y,
                       input logic [31:0] eh, input logic [31:0] el, input int lat);
    int n;
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    start = 1'b0; op = 1'($urandom); a = $urandom; b = $urandom;
    n = 1;
    while (!done && n < 64) begin
      @(negedge clk);
      n++;
    end
    check({nm, " latency"}, 64'(n), 64'(lat));
    check({nm, " hi"}, 64'(hi), 64'(eh));
    check({nm, " lo"}, 64'(lo), 64'(el));
    @(negedge clk);
    check({nm, " busy after"}, 64'(busy), 64'h0);
    check({nm, " lo held"}, 64'(lo), 64'(el));
  endtask

  initial begin
    int n;
    int k;
    int d1;
    int d2;
    reset = 1'b1; start = 1'b0; op = 1'b0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check("reset busy", 64'(busy), 64'h0);
    check("reset done", 64'(done), 64'h0);
    check("reset hi", 64'(hi), 64'h0);
    check("reset lo", 64'(lo), 64'h0);
    chk_en = 1'b1;

    do_op("mul 7x6",   1'b0, 32'd7, 32'd6, 32'd0, 32'd42, 33);
    do_op("mul max",   1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 33);
    do_op("div 100/7", 1'b1, 32'd100, 32'd7, 32'd2, 32'd14, 33);
    do_op("div max/1", 1'b1, 32'hFFFFFFFF, 32'd1, 32'd0, 32'hFFFFFFFF, 33);
    do_op("div msb",   1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0, 33);
    do_op("div by 0",  1'b1, 32'd5, 32'd0, 32'd5, 32'hFFFFFFFF, 1);

    // start pulsed mid-run must be ignored
    @(negedge clk);
    start = 1'b1; op = 1'b0; a = 32'd7; b = 32'd6;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    start = 1'b1; a = 32'd3; b = 32'd3;
    @(negedge clk);
    start = 1'b0;
    n = 11;
    while (!done && n < 64) begin
      @(negedge clk);
      n++;
    end
    check("ignored start latency", 64'(n), 64'd33);
    check("ignored start lo", 64'(lo), 64'd42);
    check("ignored start hi", 64'(hi), 64'd0);
    @(negedge clk);

    // reset aborts a running divide
    start = 1'b1; op = 1'b1; a = 32'd100; b = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (19) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort busy", 64'(busy), 64'h0);
    check("abort hi", 64'(hi), 64'h0);
    check("abort lo", 64'(lo), 64'h0);
    k = 0;
    repeat (40) begin
      if (done) k++;
      @(negedge clk);
    end
    check("abort no done", 64'(k), 64'h0);

    // back-to-back with start held high
    start = 1'b1; op = 1'b0; a = 32'd2; b = 32'd3;
    @(negedge clk);
    op = 1'b1; a = 32'd9; b = 32'd2;
    d1 = -1; d2 = -1;
    for (int i = 1; i < 200 && d2 < 0; i++) begin
      if (i > 1) @(negedge clk);
      if (done) begin
        if (d1 < 0) begin
          d1 = i;
          check("b2b mul lo", 64'(lo), 64'd6);
          check("b2b mul hi", 64'(hi), 64'd0);
        end else begin
          d2 = i;
          start = 1'b0;
        end
      end
    end
    check("b2b first done", 64'(d1), 64'd33);
    check("b2b gap", 64'(d2 - d1), 64'd34);
    check("b2b div lo", 64'(lo), 64'd4);
    check("b2b div hi", 64'(hi), 64'd1);
    repeat (3) @(negedge clk);

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_muldiv_seq.md
Name: alu_muldiv_seq

Overview:
Multi-cycle sequencer that performs unsigned 32x32 multiply (MULTU) and unsigned 32/32 divide (DIVU) by time-sharing the existing 32-bit ALU. The ALU does the add or subtract for each iteration, one iteration per clock. Results go into HI/LO registers. It sits beside the EX stage, and the pipeline stalls on busy.

Parameters:
- ITER, 32, number of iterations per operation; equals the operand width and is fixed at 32.
- CTRL_ADD, 3'b010, ALU control code for add.
- CTRL_SUB, 3'b110, ALU control code for subtract.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request a new operation; sampled only in IDLE.
- op  input  1  0 = MULTU, 1 = DIVU; sampled with start.
- a  input  32  multiplicand or dividend; sampled with start.
- b  input  32  multiplier or divisor; sampled with start.
- busy  output  1  high in RUN and DONE.
- done  output  1  one-cycle pulse; HI/LO are valid from this cycle.
- hi  output  32  MULTU: product[63:32]. DIVU: remainder.
- lo  output  32  MULTU: product[31:0]. DIVU: quotient.
- alu_a  output  32  ALU operand A.
- alu_b  output  32  ALU operand B.
- alu_ctrl  output  3  ALU control.
- alu_out  input  32  ALU result, combinational from alu_a, alu_b and alu_ctrl in the same cycle.

Behaviour:
- Registers:
  - state: IDLE, RUN or DONE.
  - cnt: 6-bit iteration counter.
  - opr: operand register holding the multiplicand or divisor.
  - op_r: latched op.
  - hi, lo.
- Reset: state=IDLE, cnt=0, hi=0, lo=0, opr=0, busy=0, done=0. Reset during RUN or DONE aborts the operation and no done is produced.
- ALU drive in IDLE and DONE: alu_a=0, alu_b=0, alu_ctrl=3'b000.
- IDLE, start=1, edge E0:
  - opr <= (op ? b : a), op_r <= op, cnt <= 0.
  - MULTU: hi <= 0, lo <= b.
  - DIVU: hi <= 0, lo <= a.
  - Next state is RUN, except DIVU with b==0, which goes straight to DONE with hi <= a, lo <= 32'hFFFFFFFF.
- MULTU iteration, every RUN cycle:
  - alu_a=hi, alu_b=(lo[0] ? opr : 0), alu_ctrl=CTRL_ADD.
  - c = (alu_a[31]&alu_b[31]) | ((alu_a[31]|alu_b[31]) & ~alu_out[31]).
  - {hi,lo} <= {c, alu_out, lo[31:1]}.
- DIVU iteration, every RUN cycle:
  - s = {hi[30:0], lo[31]}, t = hi[31].
  - alu_a=s, alu_b=opr, alu_ctrl=CTRL_SUB.
  - geu = (s[31]&~opr[31]) | (~(s[31]^opr[31]) & ~alu_out[31]).
  - ge = t | geu.
  - hi <= (ge ? alu_out : s), lo <= {lo[30:0], ge}.
- RUN counting: cnt increments each cycle. The iteration with cnt==31 is the last; it moves the state to DONE.
- Latency: done=1 in the 33rd cycle after E0 (zero-divisor case: the first cycle after E0). DONE lasts exactly 1 cycle, then IDLE.
- Result hold: hi and lo keep their values in IDLE until the next accepted start or reset.
- start while busy: ignored, with no queuing. start is accepted again in the IDLE cycle after DONE.
- Operand changes: a, b and op may change after E0 with no effect on the running operation.

Test Plan:
1. MULTU a=7, b=6 -> done in the 33rd cycle after the start edge; hi=0, lo=42; busy high for 33 cycles.
2. MULTU a=b=32'hFFFFFFFF -> hi=32'hFFFFFFFE, lo=32'h00000001. This checks carry reconstruction.
3. DIVU a=100, b=7 -> lo=14, hi=2. Also DIVU a=32'hFFFFFFFF, b=1 -> lo=32'hFFFFFFFF, hi=0. Also DIVU a=32'h80000000, b=32'hFFFFFFFF -> lo=0, hi=32'h80000000.
4. DIVU a=5, b=0 -> done 1 cycle after the start edge; hi=5, lo=32'hFFFFFFFF; alu_ctrl stays 3'b000.
5. start pulsed with a=3, b=3 at cycle 10 of a running MULTU 7*6 -> ignored; the result is still 42. reset asserted at cycle 20 of a second operation -> busy=0, hi=lo=0 next cycle, and done never pulses.
6. Back-to-back: start held high continuously with MULTU 2*3, then DIVU 9/2 -> two done pulses, 34 cycles apart. Results: 6, then lo=4, hi=1.
